palette_loader: RTL and testbench
=================================

# palette_loader

Loads a user-supplied 256-entry RGB palette from the HPS download stream into an on-chip palette RAM. The same RAM is shared with the live pixel lookup path, so every pixel read is serviced at full rate while download writes go in between reads. The block sits beside the video mux. Once a complete palette is present, `pal_loaded` tells the mux to take `vid_color` in place of the built-in temperature palettes.

## Interface

Parameters:
- `ENTRIES`, 256: palette depth; index width is clog2(ENTRIES).
- `BYTES_PER_ENTRY`, 3: bytes per entry, in R, G, B order.

Ports:
- `clk_sys`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `dl_active`  in  1  palette download in progress (already qualified by ioctl index).
- `dl_wr`  in  1  one-cycle byte strobe.
- `dl_addr`  in  10  byte address within the palette file.
- `dl_data`  in  8  byte value.
- `dl_wait`  out  1  loader must hold off `dl_wr`.
- `dl_err`  out  1  sticky protocol error flag.
- `vid_rd`  in  1  pixel lookup strobe (the delayed pixel CE).
- `vid_index`  in  8  lookup index, in {chroma, luma} format.
- `vid_color`  out  24  {R,G,B} read data.
- `vid_valid`  out  1  `vid_color` updated this cycle.
- `pal_loaded`  out  1  a complete palette is resident.

## Operation

- RAM is single-port, 256x24, with registered read. On each cycle the port serves exactly one of: the video read (`vid_rd`=1), the pending write, or nothing. Video always wins.
- FSM states:
  - IDLE: no download.
  - COLLECT: assembling bytes.
  - PEND: a 24-bit entry is waiting for a free port cycle.
- IDLE -> COLLECT on a `dl_active` rising edge. This edge clears `exp_addr`, `phase`, `pal_loaded` and `dl_err`.
- In COLLECT, `dl_wr` with `dl_addr`==`exp_addr` stores `dl_data` into byte lane `phase` (0=R, 1=G, 2=B). It then increments `exp_addr` and advances `phase` 0->1->2->0. When phase 2 is stored, the FSM goes to PEND with `wr_idx` = entry counter.
- `dl_wr` with `dl_addr`!=`exp_addr`: the byte is dropped, `dl_err` is set, and state is unchanged.
- PEND:
  - `dl_wait`=1.
  - On the first cycle with `vid_rd`=0, the entry is written. Then the entry counter increments and the FSM returns to COLLECT.
  - If the written entry is 255, `pal_loaded` is set and the FSM goes to IDLE.
  - `dl_wr` arriving during PEND is dropped and sets `dl_err`.
- `dl_active` falling while in COLLECT or PEND aborts the load: a pending entry is discarded, the FSM goes to IDLE, and `pal_loaded` stays 0.
- Bytes at addresses >= 768 go unaccepted. The FSM is already IDLE after entry 255 is written.
- `vid_rd` is never asserted on two consecutive cycles; the pixel CE runs at <= clk/2. A write therefore waits at most 1 cycle in PEND.

## Timing

- Reset values:
  - `dl_wait`=0, `dl_err`=0, `vid_color`=0, `vid_valid`=0, `pal_loaded`=0.
  - FSM=IDLE, `exp_addr`=0, `phase`=0, entry counter=0.
- RAM contents are not cleared by reset.
- Read latency:
  - `vid_rd` at cycle N -> `vid_color`=RAM[`vid_index`@N] and `vid_valid`=1 at N+1.
  - `vid_color` holds its value between reads.
- Write latency: the B byte is accepted at cycle N, and PEND is entered at N+1. The write happens at N+1 if `vid_rd`@N+1=0, otherwise at N+2.
- `dl_wait` is registered: high from the cycle after the B byte is accepted until the cycle the write executes, inclusive.
- Read-during-write cannot occur, because arbitration excludes it.
- `pal_loaded` rises the cycle after entry 255 is written.
- Simultaneous events:
  - `dl_active` fall together with a write cycle: the abort wins and no write occurs.
  - `dl_active` rise together with `dl_wr`: the byte is treated as address 0 of the new load.
  - `reset` has priority over everything.
- Reset mid-load yields the full reset state. Already-written entries remain in RAM but `pal_loaded`=0.

## Structure

- Shared package `k7800_video_pkg`:
  - `rgb_t` (24-bit packed R,G,B).
  - `PAL_ENTRIES`, `PAL_FILE_BYTES`=768.
  - FSM enum `pal_ld_state_t`.
- Sub-module: the existing `spram` (addr_width 8, data_width 24), extended with a write enable. Address, data and write-enable are muxed in this block.
- The selection of `pal_loaded`/`vid_color` against the fixed palettes stays in the video mux.

## Test plan

- Sequential download of 768 bytes with `vid_rd` idle -> RAM[k]={3k,3k+1,3k+2} mod 256 for all k; `pal_loaded`=1 one cycle after entry 255 is written; `dl_err`=0.
- Download with `vid_rd` toggling every other cycle, in phase with each B byte -> each write is deferred exactly 1 cycle; `dl_wait` high 2 cycles per entry; no read returns stale data for an already-written index.
- `vid_rd`=1 with `vid_index`=8'h1F after load -> at the next cycle `vid_color`=RAM[31] and `vid_valid`=1; `vid_color` is unchanged on following non-read cycles.
- Address skip: bytes 0, 1, then 3 -> byte 3 is dropped and `dl_err`=1; a resend of byte 2 is accepted and load continues.
- `dl_active` drops after 300 bytes -> FSM IDLE, `pal_loaded`=0. A new `dl_active` rise clears `dl_err` and the load restarts at entry 0.
- `reset` asserted during PEND -> next cycle all outputs are at their reset values and no write occurs.

Source files
------------

// File: rtl/k7800_video_pkg.sv
// Shared video definitions: palette geometry, RGB entry type, loader FSM states.
package k7800_video_pkg;

  localparam int PAL_ENTRIES    = 256;
  localparam int PAL_FILE_BYTES = 768;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    PAL_IDLE    = 2'd0,
    PAL_COLLECT = 2'd1,
    PAL_PEND    = 2'd2
  } pal_ld_state_t;

endpackage

// File: rtl/spram.sv
// Single-port RAM with registered read and write enable.
// The read register only loads on a read strobe so the output holds between reads.
module spram #(
  parameter int addr_width = 8,
  parameter int data_width = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rd_i,
  input  logic                  we_i,
  input  logic [addr_width-1:0] addr_i,
  input  logic [data_width-1:0] wdata_i,
  output logic [data_width-1:0] rdata_o
);

  logic [data_width-1:0] mem [2**addr_width];
  logic [data_width-1:0] rdata_q;

  // Array write; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  // Registered read port; a write cycle never updates the read data.
  always_ff @(posedge clk_i) begin
    if (rst_i)             rdata_q <= '0;
    else if (rd_i && !we_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/palette_loader.sv
// Palette download loader sharing one RAM port with the pixel lookup path.
// Video reads always own the port; an assembled entry waits in PEND for a free cycle.
module palette_loader
  import k7800_video_pkg::*;
#(
  parameter int ENTRIES         = PAL_ENTRIES,
  parameter int BYTES_PER_ENTRY = 3
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [9:0]  dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  output logic        dl_err,
  input  logic        vid_rd,
  input  logic [7:0]  vid_index,
  output logic [23:0] vid_color,
  output logic        vid_valid,
  output logic        pal_loaded
);

  localparam int             IW       = $clog2(ENTRIES);
  localparam logic [IW-1:0]  LAST_IDX = IW'(ENTRIES - 1);
  localparam logic [1:0]     LAST_PH  = 2'(BYTES_PER_ENTRY - 1);

  pal_ld_state_t state_q, state_d;
  logic [9:0]    exp_addr_q, exp_addr_d;
  logic [1:0]    phase_q, phase_d;
  rgb_t          entry_q, entry_d;
  logic [IW-1:0] entry_cnt_q, entry_cnt_d;
  logic          pal_loaded_q, pal_loaded_d;
  logic          dl_err_q, dl_err_d;
  logic          dl_active_q;
  logic          vid_valid_q;
  logic          ram_we;
  logic          ram_we_g;
  logic [IW-1:0] ram_addr;
  logic [23:0]   ram_rdata;

  // Next-state: restart on download rise, byte assembly, arbitrated entry write.
  always_comb begin
    state_d      = state_q;
    exp_addr_d   = exp_addr_q;
    phase_d      = phase_q;
    entry_d      = entry_q;
    entry_cnt_d  = entry_cnt_q;
    pal_loaded_d = pal_loaded_q;
    dl_err_d     = dl_err_q;
    ram_we       = 1'b0;

    // A rising dl_active starts a fresh load; a byte in the same cycle is byte 0.
    if (dl_active && !dl_active_q) begin
      state_d      = PAL_COLLECT;
      exp_addr_d   = '0;
      phase_d      = '0;
      entry_cnt_d  = '0;
      pal_loaded_d = 1'b0;
      dl_err_d     = 1'b0;
    end

    case (state_d)
      PAL_COLLECT: begin
        if (!dl_active) begin
          state_d = PAL_IDLE;
        end else if (dl_wr) begin
          if (dl_addr == exp_addr_d) begin
            case (phase_d)
              2'd0:    entry_d.r = dl_data;
              2'd1:    entry_d.g = dl_data;
              default: entry_d.b = dl_data;
            endcase
            exp_addr_d = exp_addr_d + 10'd1;
            if (phase_d == LAST_PH) begin
              phase_d = '0;
              state_d = PAL_PEND;
            end else begin
              phase_d = phase_d + 2'd1;
            end
          end else begin
            dl_err_d = 1'b1;
          end
        end
      end
      PAL_PEND: begin
        // Abort beats a write landing in the same cycle.
        if (!dl_active) begin
          state_d = PAL_IDLE;
        end else begin
          if (dl_wr) dl_err_d = 1'b1;
          if (!vid_rd) begin
            ram_we      = 1'b1;
            entry_cnt_d = entry_cnt_q + IW'(1);
            if (entry_cnt_q == LAST_IDX) begin
              pal_loaded_d = 1'b1;
              state_d      = PAL_IDLE;
            end else begin
              state_d = PAL_COLLECT;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // State registers. dl_active_q resets high so a download still asserted
  // across reset must drop and rise again before a new load begins.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= PAL_IDLE;
      exp_addr_q   <= '0;
      phase_q      <= '0;
      entry_q      <= '0;
      entry_cnt_q  <= '0;
      pal_loaded_q <= 1'b0;
      dl_err_q     <= 1'b0;
      dl_active_q  <= 1'b1;
      vid_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_addr_q   <= exp_addr_d;
      phase_q      <= phase_d;
      entry_q      <= entry_d;
      entry_cnt_q  <= entry_cnt_d;
      pal_loaded_q <= pal_loaded_d;
      dl_err_q     <= dl_err_d;
      dl_active_q  <= dl_active;
      vid_valid_q  <= vid_rd;
    end
  end

  // Port mux: video read owns the address whenever it strobes.
  assign ram_we_g = ram_we && !reset;
  assign ram_addr = vid_rd ? vid_index[IW-1:0] : entry_cnt_q;

  spram #(
    .addr_width (IW),
    .data_width (24)
  ) u_ram (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .rd_i    (vid_rd),
    .we_i    (ram_we_g),
    .addr_i  (ram_addr),
    .wdata_i (entry_q),
    .rdata_o (ram_rdata)
  );

  assign dl_wait    = (state_q == PAL_PEND);
  assign dl_err     = dl_err_q;
  assign pal_loaded = pal_loaded_q;
  assign vid_valid  = vid_valid_q;
  assign vid_color  = ram_rdata;

endmodule

// File: tb/tb_palette_loader.sv
// Directed bench for palette_loader: full load, deferred writes, address skip,
// abort/restart and reset during a pending write.
module tb_palette_loader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        dl_active;
  logic        dl_wr;
  logic [9:0]  dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;
  logic        dl_err;
  logic        vid_rd;
  logic [7:0]  vid_index;
  logic [23:0] vid_color;
  logic        vid_valid;
  logic        pal_loaded;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk_sys = ~clk_sys;

  palette_loader dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .dl_active  (dl_active),
    .dl_wr      (dl_wr),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .dl_wait    (dl_wait),
    .dl_err     (dl_err),
    .vid_rd     (vid_rd),
    .vid_index  (vid_index),
    .vid_color  (vid_color),
    .vid_valid  (vid_valid),
    .pal_loaded (pal_loaded)
  );

  // Entry k of the first load: bytes are the low 8 bits of their file address.
  function automatic logic [23:0] pat1(input int k);
    return {8'(3*k), 8'(3*k+1), 8'(3*k+2)};
  endfunction

  // Entry k of the second load: same, XOR 0x5A per byte.
  function automatic logic [23:0] pat2(input int k);
    return pat1(k) ^ 24'h5A5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input int a, input logic [7:0] d);
    dl_wr   = 1'b1;
    dl_addr = 10'(a);
    dl_data = d;
    step();
    dl_wr   = 1'b0;
  endtask

  task automatic wait_free();
    int n = 0;
    while (dl_wait && n < 8) begin
      step();
      n++;
    end
    chk("wait_free", {31'd0, dl_wait}, 32'd0);
  endtask

  task automatic rd(input int idx, input logic [23:0] exp, input string tag);
    vid_rd    = 1'b1;
    vid_index = 8'(idx);
    step();
    vid_rd    = 1'b0;
    chk(tag, {8'd0, vid_color}, {8'd0, exp});
    chk("vid_valid", {31'd0, vid_valid}, 32'd1);
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    vid_rd = 1'b0; vid_index = '0;
    step(); step();
    chk("rst_dl_wait",    {31'd0, dl_wait},    32'd0);
    chk("rst_dl_err",     {31'd0, dl_err},     32'd0);
    chk("rst_vid_color",  {8'd0, vid_color},   32'd0);
    chk("rst_vid_valid",  {31'd0, vid_valid},  32'd0);
    chk("rst_pal_loaded", {31'd0, pal_loaded}, 32'd0);
    reset = 1'b0;
    step();

    // Full sequential load with no video traffic.
    dl_active = 1'b1;
    step();
    for (int a = 0; a < 767; a++) begin
      wait_free();
      send_byte(a, 8'(a));
    end
    wait_free();
    chk("pal_before_last", {31'd0, pal_loaded}, 32'd0);
    send_byte(767, 8'(767));
    chk("last_wait",       {31'd0, dl_wait},    32'd1);
    chk("last_pal_early",  {31'd0, pal_loaded}, 32'd0);
    step();
    chk("last_wait_clr",   {31'd0, dl_wait},    32'd0);
    chk("pal_loaded",      {31'd0, pal_loaded}, 32'd1);
    chk("load1_err",       {31'd0, dl_err},     32'd0);
    for (int k = 0; k < 256; k++) rd(k, pat1(k), "load1_ram");

    // Lookup of index 0x1F and hold on idle cycles.
    rd(8'h1F, pat1(31), "rd_1f");
    chk("hold_valid", {31'd0, vid_valid}, 32'd0);
    chk("hold_color", {8'd0, vid_color},  {8'd0, pat1(31)});
    step();
    chk("hold_color2", {8'd0, vid_color}, {8'd0, pat1(31)});

    // Drop in IDLE keeps the palette; rise together with byte 0 restarts.
    dl_active = 1'b0;
    step();
    chk("idle_drop_pal", {31'd0, pal_loaded}, 32'd1);
    dl_active = 1'b1;
    send_byte(0, 8'h00 ^ 8'h5A);
    chk("rise_pal_clr", {31'd0, pal_loaded}, 32'd0);
    chk("rise_err",     {31'd0, dl_err},     32'd0);

    // Reads in phase with each B byte defer the write by one cycle.
    for (int e = 0; e < 4; e++) begin
      for (int l = 0; l < 3; l++) begin
        if (!(e == 0 && l == 0)) send_byte(3*e + l, 8'(3*e + l) ^ 8'h5A);
      end
      chk("defer_wait1", {31'd0, dl_wait}, 32'd1);
      vid_rd    = 1'b1;
      vid_index = (e == 0) ? 8'd255 : 8'(e - 1);
      step();
      vid_rd = 1'b0;
      chk("defer_wait2", {31'd0, dl_wait}, 32'd1);
      chk("defer_rd", {8'd0, vid_color}, {8'd0, (e == 0) ? pat1(255) : pat2(e - 1)});
      step();
      chk("defer_wait_clr", {31'd0, dl_wait}, 32'd0);
    end

    // Address skip: 12, 13, then 15 is dropped; resent 14 completes entry 4.
    send_byte(12, 8'(12) ^ 8'h5A);
    send_byte(13, 8'(13) ^ 8'h5A);
    send_byte(15, 8'(15) ^ 8'h5A);
    chk("skip_err",  {31'd0, dl_err},  32'd1);
    chk("skip_wait", {31'd0, dl_wait}, 32'd0);
    send_byte(14, 8'(14) ^ 8'h5A);
    chk("resend_wait", {31'd0, dl_wait}, 32'd1);
    step();
    chk("err_sticky", {31'd0, dl_err}, 32'd1);

    // Continue to 300 bytes (entries 0..99), then abort.
    for (int a = 15; a < 300; a++) begin
      wait_free();
      send_byte(a, 8'(a) ^ 8'h5A);
    end
    wait_free();
    dl_active = 1'b0;
    step();
    chk("abort_pal",  {31'd0, pal_loaded}, 32'd0);
    chk("abort_wait", {31'd0, dl_wait},    32'd0);
    rd(4,   pat2(4),   "abort_rd4");
    rd(99,  pat2(99),  "abort_rd99");
    rd(100, pat1(100), "abort_rd100");

    // New rise clears the error and restarts at entry 0.
    dl_active = 1'b1;
    step();
    chk("restart_err", {31'd0, dl_err}, 32'd0);
    send_byte(0, 8'hA0);
    send_byte(1, 8'hA1);
    send_byte(2, 8'hA2);
    wait_free();
    rd(0, 24'hA0A1A2, "restart_rd0");

    // Reset during PEND: everything back to reset values, no write.
    send_byte(3, 8'hA3);
    send_byte(4, 8'hA4);
    send_byte(5, 8'hA5);
    chk("pend_wait", {31'd0, dl_wait}, 32'd1);
    reset = 1'b1;
    dl_active = 1'b0;
    step();
    chk("prst_dl_wait",    {31'd0, dl_wait},    32'd0);
    chk("prst_dl_err",     {31'd0, dl_err},     32'd0);
    chk("prst_vid_color",  {8'd0, vid_color},   32'd0);
    chk("prst_vid_valid",  {31'd0, vid_valid},  32'd0);
    chk("prst_pal_loaded", {31'd0, pal_loaded}, 32'd0);
    reset = 1'b0;
    step();
    step();
    rd(1, pat2(1), "prst_no_write");
    rd(0, 24'hA0A1A2, "prst_kept0");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
